// File: rtl/emu_io_bridge_if.sv
// Pad/board-side bundle for the emulation I/O bridge: raw pad inputs and board
// switches toward the bridge, synchronised and registered results back out.
interface emu_io_bridge_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned SW_W   = 2
);
    logic              pll_lock_i;
    logic [DATA_W-1:0] data_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [SW_W-1:0]   switch_i;
    logic [OUT_W-1:0]  core_out_i;
    logic              core_err_i;

    logic [DATA_W-1:0] data_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [SW_W-1:0]   switch_o;
    logic [OUT_W-1:0]  out_o;
    logic              core_rst_n_o;
    logic [7:0]        err_cnt_o;
    logic [15:0]       led_o;

    modport slave (
        input  pll_lock_i, data_i, ctrl_i, switch_i, core_out_i, core_err_i,
        output data_o, ctrl_o, switch_o, out_o, core_rst_n_o, err_cnt_o, led_o
    );

    modport master (
        output pll_lock_i, data_i, ctrl_i, switch_i, core_out_i, core_err_i,
        input  data_o, ctrl_o, switch_o, out_o, core_rst_n_o, err_cnt_o, led_o
    );
endinterface

// File: rtl/emu_io_bridge.sv
// Emulation board I/O bridge: pad synchronisers, switch debouncers, lock-qualified
// core reset sequencer, saturating error counter and paged debug LEDs.
module emu_io_bridge #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CTRL_W      = 3,
    parameter int unsigned OUT_W       = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SW_W        = 2,
    parameter int unsigned DEB_LEN     = 65536,
    parameter int unsigned RST_HOLD    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    emu_io_bridge_if.slave bus
);
    localparam int unsigned DEB_CW  = $clog2(DEB_LEN);
    localparam int unsigned HOLD_CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync;
    logic [SYNC_STAGES-1:0][CTRL_W-1:0] ctrl_sync;
    logic [OUT_W-1:0]                   out_q;

    logic [1:0]         lock_sync;
    logic               lock_s;
    state_t             state;
    logic [HOLD_CW-1:0] hold_cnt;
    logic               core_rst_n_q;

    logic [SW_W-1:0]             sw_meta;
    logic [SW_W-1:0]             sw_s;
    logic [SW_W-1:0]             sw_q;
    logic [SW_W-1:0][DEB_CW-1:0] deb_cnt;

    logic [7:0]  err_cnt;
    logic [1:0]  page;
    logic        sw_top_q;
    logic [23:0] hb;
    logic [15:0] led_q;
    logic [15:0] led_next_c;

    // Pad data/control synchronisers and core output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync <= '0;
            ctrl_sync <= '0;
            out_q     <= '0;
        end else begin
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.data_i};
            ctrl_sync <= {ctrl_sync[SYNC_STAGES-2:0], bus.ctrl_i};
            out_q     <= bus.core_out_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync <= '0;
        else        lock_sync <= {lock_sync[0], bus.pll_lock_i};
    end

    assign lock_s = lock_sync[1];

    // Core reset sequencer; core reset releases only after a full clean HOLD window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_LOCK;
            hold_cnt     <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    core_rst_n_q <= 1'b0;
                    if (lock_s) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (hold_cnt == HOLD_CW'(RST_HOLD - 1)) begin
                        state        <= RUN;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_CW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state        <= WAIT_LOCK;
                        core_rst_n_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= WAIT_LOCK;
                    core_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    // Switch synchronisers and per-bit debouncers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_s    <= '0;
            sw_q    <= '0;
            deb_cnt <= '0;
        end else begin
            sw_meta <= bus.switch_i;
            sw_s    <= sw_meta;
            for (int i = 0; i < int'(SW_W); i++) begin
                if (sw_s[i] != sw_q[i]) begin
                    if (deb_cnt[i] == DEB_CW'(DEB_LEN - 1)) begin
                        sw_q[i]    <= sw_s[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_CW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Error-cycle counter, LED page stepping and heartbeat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            page     <= '0;
            sw_top_q <= 1'b0;
            hb       <= '0;
        end else begin
            if (state == RUN && bus.core_err_i && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            sw_top_q <= sw_q[SW_W-1];
            if (sw_q[SW_W-1] && !sw_top_q)
                page <= page + 2'd1;
            hb <= hb + 24'd1;
        end
    end

    always_comb begin
        led_next_c = '0;
        case (page)
            2'd0:    led_next_c = {err_cnt, 4'b0000, err_cnt != 8'd0, state, core_rst_n_q};
            2'd1:    led_next_c = 16'({data_sync[SYNC_STAGES-1], ctrl_sync[SYNC_STAGES-1]});
            2'd2:    led_next_c = 16'(out_q);
            default: led_next_c = hb[23:8];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= '0;
        else        led_q <= led_next_c;
    end

    assign bus.data_o       = data_sync[SYNC_STAGES-1];
    assign bus.ctrl_o       = ctrl_sync[SYNC_STAGES-1];
    assign bus.switch_o     = sw_q;
    assign bus.out_o        = out_q;
    assign bus.core_rst_n_o = core_rst_n_q;
    assign bus.err_cnt_o    = err_cnt;
    assign bus.led_o        = led_q;
endmodule

// File: tb/tb_emu_io_bridge.sv
// Bench for emu_io_bridge: random pad traffic checked every cycle against a
// history-based reference model, plus directed timing/boundary checks.
module tb_emu_io_bridge;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CTRL_W      = 3;
    localparam int unsigned OUT_W       = 10;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned SW_W        = 2;
    localparam int unsigned DEB_LEN     = 8;
    localparam int unsigned RST_HOLD    = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    emu_io_bridge_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .OUT_W(OUT_W), .SW_W(SW_W)) bus ();

    emu_io_bridge #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .OUT_W(OUT_W), .SYNC_STAGES(SYNC_STAGES),
        .SW_W(SW_W), .DEB_LEN(DEB_LEN), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Scenario knobs
    bit            lock_v;
    bit            err_v;
    bit            err_rand;
    bit            fix_en;
    bit [SW_W-1:0] sw_v;

    // Input histories, newest first (index k = driven k+1 edges ago)
    logic [DATA_W-1:0] dq[$];
    logic [CTRL_W-1:0] cq[$];
    logic [OUT_W-1:0]  oq[$];
    logic              lq[$];
    logic              eq[$];
    logic [SW_W-1:0]   swq[$];

    // Expected outputs
    logic [DATA_W-1:0] data_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic [OUT_W-1:0]  out_e;
    logic [SW_W-1:0]   sw_e;
    logic [15:0]       led_e;
    logic [23:0]       hb_e;
    int                run_len;
    int                st_e;
    bit                rst_e;
    int                err_e;
    int                page_e;
    bit                sw_top_d;
    int                mis_len[SW_W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        dq.delete(); cq.delete(); oq.delete(); lq.delete(); eq.delete(); swq.delete();
        for (int i = 0; i < 4; i++) begin
            dq.push_front('0); cq.push_front('0); oq.push_front('0);
            lq.push_front(1'b0); eq.push_front(1'b0); swq.push_front('0);
        end
        data_e = '0; ctrl_e = '0; out_e = '0; sw_e = '0; led_e = '0; hb_e = '0;
        run_len = 0; st_e = 0; rst_e = 1'b0; err_e = 0; page_e = 0; sw_top_d = 1'b0;
        for (int i = 0; i < int'(SW_W); i++) mis_len[i] = 0;
    endfunction

    // One clock edge of the reference behaviour, from the values held before it
    function automatic void model_update();
        logic [15:0] led_n;
        case (page_e)
            0:       led_n = {8'(err_e), 4'b0000, err_e != 0, 2'(st_e), rst_e};
            1:       led_n = 16'({data_e, ctrl_e});
            2:       led_n = 16'(out_e);
            default: led_n = hb_e[23:8];
        endcase
        if (sw_e[SW_W-1] && !sw_top_d) page_e = (page_e + 1) % 4;
        sw_top_d = sw_e[SW_W-1];
        if (st_e == 2 && eq[0]) err_e = (err_e < 255) ? err_e + 1 : 255;
        // Lock seen by the sequencer is the pad value from three edges back
        run_len = lq[2] ? ((run_len < 100000) ? run_len + 1 : run_len) : 0;
        st_e    = (run_len == 0) ? 0 : (run_len <= int'(RST_HOLD)) ? 1 : 2;
        rst_e   = (st_e == 2);
        for (int i = 0; i < int'(SW_W); i++) begin
            if (swq[2][i] != sw_e[i]) begin
                mis_len[i]++;
                if (mis_len[i] == int'(DEB_LEN)) begin
                    sw_e[i]    = swq[2][i];
                    mis_len[i] = 0;
                end
            end else begin
                mis_len[i] = 0;
            end
        end
        data_e = dq[SYNC_STAGES-1];
        ctrl_e = cq[SYNC_STAGES-1];
        out_e  = oq[0];
        led_e  = led_n;
        hb_e   = hb_e + 24'd1;
    endfunction

    task automatic check_all();
        chk("data_o",       32'(bus.data_o),       32'(data_e));
        chk("ctrl_o",       32'(bus.ctrl_o),       32'(ctrl_e));
        chk("out_o",        32'(bus.out_o),        32'(out_e));
        chk("switch_o",     32'(bus.switch_o),     32'(sw_e));
        chk("core_rst_n_o", 32'(bus.core_rst_n_o), 32'(rst_e));
        chk("err_cnt_o",    32'(bus.err_cnt_o),    32'(err_e));
        chk("led_o",        32'(bus.led_o),        32'(led_e));
    endtask

    // Drive one cycle of inputs, take the edge, then check against the model
    task automatic cycle();
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic [OUT_W-1:0]  o;
        logic              e;
        d = fix_en ? DATA_W'(8'hA5)  : DATA_W'($urandom);
        c = fix_en ? CTRL_W'(3'b101) : CTRL_W'($urandom);
        o = fix_en ? OUT_W'(10'h3FF) : OUT_W'($urandom);
        e = err_rand ? 1'($urandom) : err_v;
        bus.data_i     = d;
        bus.ctrl_i     = c;
        bus.core_out_i = o;
        bus.core_err_i = e;
        bus.pll_lock_i = lock_v;
        bus.switch_i   = sw_v;
        dq.push_front(rst_n ? d : '0);             void'(dq.pop_back());
        cq.push_front(rst_n ? c : '0);             void'(cq.pop_back());
        oq.push_front(rst_n ? o : '0);             void'(oq.pop_back());
        eq.push_front(rst_n ? e : 1'b0);           void'(eq.pop_back());
        lq.push_front(rst_n ? lock_v : 1'b0);      void'(lq.pop_back());
        swq.push_front(rst_n ? sw_v : '0);         void'(swq.pop_back());
        @(posedge clk);
        #1;
        if (rst_n) model_update();
        check_all();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
    endtask

    int n;
    int n1;
    int n2;

    initial begin
        rst_n = 1'b1;
        lock_v = 1'b0; err_v = 1'b0; err_rand = 1'b0; fix_en = 1'b0; sw_v = '0;
        bus.data_i = '0; bus.ctrl_i = '0; bus.core_out_i = '0; bus.core_err_i = 1'b0;
        bus.pll_lock_i = 1'b0; bus.switch_i = '0;
        #2;
        apply_reset();
        repeat (3) cycle();
        chk("reset_led", 32'(bus.led_o), 32'h0);

        // Errors before lock must not count
        rst_n = 1'b1;
        err_v = 1'b1;
        repeat (10) cycle();
        chk("err_in_wait_lock", 32'(bus.err_cnt_o), 32'd0);

        // Lock to core reset release
        err_v = 1'b0; lock_v = 1'b1; n = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (bus.core_rst_n_o === 1'b1) begin n = i; break; end
        end
        chk("lock_to_run_edges", 32'(n), 32'd19);
        cycle();
        chk("run_state_led", 32'(bus.led_o[2:0]), 32'b101);

        // Saturating error counter
        err_v = 1'b1;
        repeat (300) cycle();
        chk("err_saturated", 32'(bus.err_cnt_o), 32'd255);
        err_v = 1'b0; err_rand = 1'b1;
        repeat (20) cycle();
        err_rand = 1'b0;

        // Lock loss in RUN and full re-qualification
        lock_v = 1'b0; n = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (bus.core_rst_n_o === 1'b0) begin n = i; break; end
        end
        chk("lock_drop_edges", 32'(n), 32'd3);
        lock_v = 1'b1; n = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (bus.core_rst_n_o === 1'b1) begin n = i; break; end
        end
        chk("rehold_edges", 32'(n), 32'd19);

        // Synchroniser and output register latency
        fix_en = 1'b1;
        cycle();
        fix_en = 1'b0;
        chk("out_one_edge", 32'(bus.out_o), 32'h3FF);
        cycle();
        chk("data_sync_edges", 32'(bus.data_o), 32'hA5);
        chk("ctrl_sync_edges", 32'(bus.ctrl_o), 32'h5);

        // Debounce: short glitch rejected, long hold accepted
        sw_v[0] = 1'b1;
        repeat (5) cycle();
        sw_v[0] = 1'b0;
        repeat (15) cycle();
        chk("glitch_rejected", 32'(bus.switch_o[0]), 32'd0);
        sw_v[0] = 1'b1; n = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (bus.switch_o[0] === 1'b1) begin n = i; break; end
        end
        chk("debounce_edges", 32'(n), 32'd10);
        repeat (10) cycle();

        // LED pages 1,2,3,0
        for (int p = 1; p <= 4; p++) begin
            sw_v[1] = 1'b1;
            fix_en  = (p == 1 || p == 2);
            repeat (14) cycle();
            if (p == 1) chk("led_page1", 32'(bus.led_o), 32'h052D);
            if (p == 2) chk("led_page2", 32'(bus.led_o), 32'h03FF);
            if (p == 4) chk("led_page0", 32'(bus.led_o), 32'hFF0D);
            fix_en  = 1'b0;
            sw_v[1] = 1'b0;
            repeat (12) cycle();
        end

        // Reset mid-HOLD and mid-debounce discards progress
        lock_v = 1'b0;
        repeat (4) cycle();
        lock_v = 1'b1; sw_v[0] = 1'b0;
        repeat (8) cycle();
        apply_reset();
        chk("mid_reset_led", 32'(bus.led_o), 32'h0);
        chk("mid_reset_sw", 32'(bus.switch_o), 32'h0);
        repeat (2) cycle();
        rst_n = 1'b1; sw_v[0] = 1'b1; n1 = 0; n2 = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (n1 == 0 && bus.core_rst_n_o === 1'b1) n1 = i;
            if (n2 == 0 && bus.switch_o[0] === 1'b1) n2 = i;
        end
        chk("post_reset_hold_edges", 32'(n1), 32'd19);
        chk("post_reset_debounce_edges", 32'(n2), 32'd10);

        // Random lock, switch and error activity
        err_rand = 1'b1;
        for (int s = 0; s < 30; s++) begin
            lock_v = ($urandom_range(0, 3) != 0);
            sw_v   = SW_W'($urandom);
            repeat ($urandom_range(1, 30)) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/emu_io_bridge.md
EMU_IO_BRIDGE -- requirements
Module: emu_io_bridge

Interface
REQ-001 Parameter DATA_W, default 8, width of the data input bus and of data_o.
REQ-002 Parameter CTRL_W, default 3, width of the control input bus and of ctrl_o.
REQ-003 Parameter OUT_W, default 10, width of the core output bus and of out_o.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth; legal range 2..4.
REQ-005 Parameter SW_W, default 2, number of debounced switches; minimum 2.
REQ-006 Parameter DEB_LEN, default 65536, count of consecutive stable cycles needed to accept a switch change; minimum 2.
REQ-007 Parameter RST_HOLD, default 16, number of cycles core reset is held after lock qualifies; minimum 1.
REQ-008 clk  in  1  single clock for all logic.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 pll_lock_i  in  1  raw PLL lock, asynchronous to clk.
REQ-011 data_i  in  DATA_W  raw pad data, asynchronous.
REQ-012 ctrl_i  in  CTRL_W  raw pad control, asynchronous.
REQ-013 switch_i  in  SW_W  raw board switches; bit SW_W-1 is the LED page switch.
REQ-014 core_out_i  in  OUT_W  core outputs to be registered toward pads.
REQ-015 core_err_i  in  1  core hardware-error pulse or level.
REQ-016 data_o  out  DATA_W  synchronised data.
REQ-017 ctrl_o  out  CTRL_W  synchronised control.
REQ-018 switch_o  out  SW_W  debounced switches.
REQ-019 out_o  out  OUT_W  registered core outputs.
REQ-020 core_rst_n_o  out  1  sequenced active-low core reset.
REQ-021 err_cnt_o  out  8  saturating error-cycle count.
REQ-022 led_o  out  16  paged debug LEDs.

Function
REQ-023 data_o/ctrl_o SHALL equal data_i/ctrl_i delayed by exactly SYNC_STAGES clk edges.
REQ-024 out_o SHALL equal core_out_i delayed by exactly 1 clk edge.
REQ-025 pll_lock_i SHALL pass a fixed 2-flop synchroniser, giving lock_s.
REQ-026 Reset sequencer states: WAIT_LOCK, HOLD, RUN; core_rst_n_o is 1 only in RUN, registered.
REQ-027 WAIT_LOCK -> HOLD when lock_s=1; hold counter cleared on entry.
REQ-028 HOLD -> RUN after RST_HOLD cycles in HOLD with lock_s=1; any cycle with lock_s=0 in HOLD or RUN -> WAIT_LOCK on the next edge.
REQ-029 Each switch SHALL pass a 2-flop synchroniser, then a per-bit debouncer: counter increments while synced value != switch_o bit, clears when equal.
REQ-030 When a debounce counter reaches DEB_LEN-1 with mismatch still present, switch_o bit SHALL take the synced value on that edge and the counter SHALL clear; glitches shorter than DEB_LEN cycles never reach switch_o.
REQ-031 err_cnt_o SHALL increment by 1 on every cycle with core_err_i=1 and state RUN, saturating at 255 (no wrap); cleared only by rst_n.
REQ-032 A 2-bit page register SHALL increment (mod 4, wrap 3->0) on each rising edge of switch_o[SW_W-1].
REQ-033 Page 0: led_o = {err_cnt_o, 4'b0, err_cnt_o!=0, state[1:0], core_rst_n_o}, state encoding WAIT_LOCK=0, HOLD=1, RUN=2.
REQ-034 Page 1: led_o = {data_o, ctrl_o} zero-extended/truncated to 16 bits, LSB-aligned.
REQ-035 Page 2: led_o = out_o zero-extended/truncated to 16 bits, LSB-aligned.
REQ-036 Page 3: led_o = upper 16 bits of a free-running 24-bit heartbeat counter (wraps).
REQ-037 led_o SHALL be registered (1 cycle after source change).

Reset
REQ-038 On rst_n=0 all flops SHALL clear immediately: data_o, ctrl_o, switch_o, out_o, err_cnt_o, led_o = 0; core_rst_n_o = 0; state WAIT_LOCK; page 0; all counters 0.
REQ-039 Reset asserted mid-HOLD or mid-debounce SHALL discard progress; after release the full RST_HOLD/DEB_LEN intervals restart.

Verification
REQ-040 Defaults, rst_n release, pll_lock_i=1 held -> core_rst_n_o rises 2+1+16 edges after lock applied (±1 for sync alignment), state RUN.
REQ-041 In RUN, drop pll_lock_i for 3 cycles -> core_rst_n_o=0 within 3 edges; re-raise -> full 16-cycle HOLD repeated.
REQ-042 DEB_LEN=8: switch_i[0] pulse 5 cycles -> switch_o[0] stays 0; held 20 cycles -> switch_o[0]=1 exactly 2+8 edges after change.
REQ-043 data_i=8'hA5, ctrl_i=3'b101 stepped -> data_o/ctrl_o match after exactly SYNC_STAGES edges; core_out_i=10'h3FF -> out_o after 1 edge.
REQ-044 core_err_i held high 300 cycles in RUN -> err_cnt_o saturates at 255; core_err_i high in WAIT_LOCK -> no increment.
REQ-045 Four debounced page-switch rising edges -> pages 1,2,3,0 with led_o contents per REQ-033..036; rst_n pulse -> page 0, led_o=0.
